// File: rtl/cache_control.sv
// Control sequencer for the 2-way, 8-set write-back cache datapath.
// Mealy outputs are decoded from the registered state and the live datapath status.
module cache_control #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_read,
    input  logic                 mem_write,
    output logic                 mem_resp,
    output logic                 pmem_read,
    output logic                 pmem_write,
    input  logic                 pmem_resp,
    input  logic                 hit0,
    input  logic                 hit1,
    input  logic                 dirty_bit,
    input  logic                 valid_bit,
    input  logic                 lru_out,
    output logic                 lru_load,
    output logic                 read_array,
    output logic                 write_array,
    output logic                 data_select,
    output logic                 dirty_select,
    output logic                 pmem_select,
    output logic [1:0]           write0_select,
    output logic [1:0]           write1_select,
    output logic                 valid_load0,
    output logic                 valid_load1,
    output logic                 tag_load0,
    output logic                 tag_load1,
    output logic                 dirty_load0,
    output logic                 dirty_load1,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        WRITEBACK,
        ALLOCATE
    } state_e;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_CPU  = 2'b01;
    localparam logic [1:0] SEL_LINE = 2'b10;

    state_e               state_q, state_d;
    logic                 refill_q, refill_d;
    logic [CNT_WIDTH-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            refill_q   <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            refill_q   <= refill_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        refill_d      = refill_q;
        hit_cnt_d     = hit_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        lru_load      = 1'b0;
        read_array    = 1'b0;
        write_array   = 1'b0;
        data_select   = 1'b0;
        dirty_select  = 1'b0;
        pmem_select   = 1'b0;
        write0_select = SEL_NONE;
        write1_select = SEL_NONE;
        valid_load0   = 1'b0;
        valid_load1   = 1'b0;
        tag_load0     = 1'b0;
        tag_load1     = 1'b0;
        dirty_load0   = 1'b0;
        dirty_load1   = 1'b0;

        unique case (state_q)
            IDLE: begin
                refill_d = 1'b0;
                if (mem_read || mem_write) begin
                    state_d = CHECK;
                end
            end

            CHECK: begin
                read_array  = mem_read;
                write_array = mem_write;
                if (hit0 || hit1) begin
                    mem_resp  = 1'b1;
                    lru_load  = 1'b1;
                    hit_cnt_d = hit_cnt_q + CNT_WIDTH'(1);
                    state_d   = IDLE;
                    // A combined read+write request takes this write path.
                    if (mem_write) begin
                        dirty_select = 1'b1;
                        if (hit0) begin
                            write0_select = SEL_CPU;
                            dirty_load0   = 1'b1;
                        end else begin
                            write1_select = SEL_CPU;
                            dirty_load1   = 1'b1;
                        end
                    end
                end else begin
                    // The re-check after a refill must not count the same request twice.
                    if (!refill_q) begin
                        miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
                    end
                    state_d = (valid_bit && dirty_bit) ? WRITEBACK : ALLOCATE;
                end
            end

            WRITEBACK: begin
                read_array  = mem_read;
                write_array = mem_write;
                pmem_write  = 1'b1;
                if (pmem_resp) begin
                    state_d = ALLOCATE;
                end
            end

            ALLOCATE: begin
                read_array  = mem_read;
                write_array = mem_write;
                pmem_read   = 1'b1;
                pmem_select = 1'b1;
                data_select = 1'b1;
                if (pmem_resp) begin
                    if (lru_out) begin
                        write1_select = SEL_LINE;
                        valid_load1   = 1'b1;
                        tag_load1     = 1'b1;
                        dirty_load1   = 1'b1;
                    end else begin
                        write0_select = SEL_LINE;
                        valid_load0   = 1'b1;
                        tag_load0     = 1'b1;
                        dirty_load0   = 1'b1;
                    end
                    refill_d = 1'b1;
                    state_d  = CHECK;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_cache_control.sv
// Directed bench for cache_control: reset, hits, clean and dirty misses, counter wrap.
module tb_cache_control;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mem_read = 1'b0, mem_write = 1'b0, pmem_resp = 1'b0;
    logic          hit0 = 1'b0, hit1 = 1'b0, dirty_bit = 1'b0, valid_bit = 1'b0, lru_out = 1'b0;
    logic          mem_resp, pmem_read, pmem_write;
    logic          lru_load, read_array, write_array, data_select, dirty_select, pmem_select;
    logic [1:0]    write0_select, write1_select;
    logic          valid_load0, valid_load1, tag_load0, tag_load1, dirty_load0, dirty_load1;
    logic [CW-1:0] hit_count, miss_count;

    int n_cmp = 0;
    int n_err = 0;

    cache_control #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
        .hit0(hit0), .hit1(hit1), .dirty_bit(dirty_bit), .valid_bit(valid_bit), .lru_out(lru_out),
        .lru_load(lru_load), .read_array(read_array), .write_array(write_array),
        .data_select(data_select), .dirty_select(dirty_select), .pmem_select(pmem_select),
        .write0_select(write0_select), .write1_select(write1_select),
        .valid_load0(valid_load0), .valid_load1(valid_load1),
        .tag_load0(tag_load0), .tag_load1(tag_load1),
        .dirty_load0(dirty_load0), .dirty_load1(dirty_load1),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Move to 1 time unit past the next rising edge; inputs change here.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
        hit0 = 1'b0; hit1 = 1'b0; dirty_bit = 1'b0; valid_bit = 1'b0; lru_out = 1'b0;
    endtask

    initial begin
        // Held in reset: everything quiet.
        #3;
        chk("rst_mem_resp", 32'(mem_resp), 32'd0);
        chk("rst_hit_count", 32'(hit_count), 32'd0);
        #4 rst = 1'b0;

        // Reset while ALLOCATE is driving pmem_read.
        cyc();
        mem_read = 1'b1; valid_bit = 1'b0; lru_out = 1'b0;
        cyc();
        #1 chk("chk_no_pmem_read", 32'(pmem_read), 32'd0);
        cyc();
        #1 chk("alloc_pmem_read", 32'(pmem_read), 32'd1);
        chk("alloc_miss_count", 32'(miss_count), 32'd1);
        #2 rst = 1'b1;
        #1 chk("rst_async_pmem_read", 32'(pmem_read), 32'd0);
        chk("rst_async_mem_resp", 32'(mem_resp), 32'd0);
        chk("rst_async_idle", 32'(read_array), 32'd0);
        chk("rst_async_miss_count", 32'(miss_count), 32'd0);
        #1 rst = 1'b0;
        clear_inputs();

        // Read hit in way 0.
        cyc();
        mem_read = 1'b1; hit0 = 1'b1;
        #1 chk("rh_idle_resp", 32'(mem_resp), 32'd0);
        cyc();
        #1 chk("rh_mem_resp", 32'(mem_resp), 32'd1);
        chk("rh_lru_load", 32'(lru_load), 32'd1);
        chk("rh_w0sel", 32'(write0_select), 32'd0);
        chk("rh_w1sel", 32'(write1_select), 32'd0);
        chk("rh_read_array", 32'(read_array), 32'd1);
        cyc();
        clear_inputs();
        #1 chk("rh_resp_drop", 32'(mem_resp), 32'd0);
        chk("rh_hit_count", 32'(hit_count), 32'd1);

        // Write hit in way 1.
        cyc();
        mem_write = 1'b1; hit1 = 1'b1;
        cyc();
        #1 chk("wh_w1sel", 32'(write1_select), 32'd1);
        chk("wh_w0sel", 32'(write0_select), 32'd0);
        chk("wh_dirty_load1", 32'(dirty_load1), 32'd1);
        chk("wh_dirty_load0", 32'(dirty_load0), 32'd0);
        chk("wh_dirty_select", 32'(dirty_select), 32'd1);
        chk("wh_data_select", 32'(data_select), 32'd0);
        chk("wh_mem_resp", 32'(mem_resp), 32'd1);
        cyc();
        clear_inputs();
        #1 chk("wh_hit_count", 32'(hit_count), 32'd2);

        // Clean miss, victim way 1, memory answers on the 5th ALLOCATE cycle.
        cyc();
        mem_read = 1'b1; valid_bit = 1'b0; lru_out = 1'b1;
        cyc();
        #1 chk("cm_check_pmem_read", 32'(pmem_read), 32'd0);
        chk("cm_check_resp", 32'(mem_resp), 32'd0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (i == 4) pmem_resp = 1'b1;
            #1 chk("cm_pmem_read", 32'(pmem_read), 32'd1);
            if (i == 0) begin
                chk("cm_pmem_select", 32'(pmem_select), 32'd1);
                chk("cm_data_select", 32'(data_select), 32'd1);
                chk("cm_miss_count", 32'(miss_count), 32'd1);
                chk("cm_no_fill_early", 32'(write1_select), 32'd0);
            end
        end
        chk("cm_w1sel", 32'(write1_select), 32'd2);
        chk("cm_w0sel", 32'(write0_select), 32'd0);
        chk("cm_valid_load1", 32'(valid_load1), 32'd1);
        chk("cm_tag_load1", 32'(tag_load1), 32'd1);
        chk("cm_dirty_load1", 32'(dirty_load1), 32'd1);
        chk("cm_dirty_select", 32'(dirty_select), 32'd0);
        cyc();
        pmem_resp = 1'b0; hit1 = 1'b1;
        #1 chk("cm_pmem_read_drop", 32'(pmem_read), 32'd0);
        chk("cm_mem_resp", 32'(mem_resp), 32'd1);
        cyc();
        clear_inputs();
        #1 chk("cm_hit_count", 32'(hit_count), 32'd3);
        chk("cm_miss_count_end", 32'(miss_count), 32'd1);

        // Dirty miss, victim way 0, write request.
        cyc();
        mem_write = 1'b1; valid_bit = 1'b1; dirty_bit = 1'b1; lru_out = 1'b0;
        cyc();
        #1 chk("dm_check_pmem_write", 32'(pmem_write), 32'd0);
        cyc();
        #1 chk("dm_wb_pmem_write", 32'(pmem_write), 32'd1);
        chk("dm_wb_pmem_select", 32'(pmem_select), 32'd0);
        chk("dm_wb_pmem_read", 32'(pmem_read), 32'd0);
        chk("dm_miss_count", 32'(miss_count), 32'd2);
        cyc();
        #1 chk("dm_wb_hold", 32'(pmem_write), 32'd1);
        cyc();
        pmem_resp = 1'b1;
        #1 chk("dm_wb_resp_cycle", 32'(pmem_write), 32'd1);
        cyc();
        pmem_resp = 1'b0;
        #1 chk("dm_wb_drop", 32'(pmem_write), 32'd0);
        chk("dm_al_pmem_read", 32'(pmem_read), 32'd1);
        chk("dm_al_pmem_select", 32'(pmem_select), 32'd1);
        cyc();
        pmem_resp = 1'b1;
        #1 chk("dm_w0sel_line", 32'(write0_select), 32'd2);
        chk("dm_valid_load0", 32'(valid_load0), 32'd1);
        chk("dm_tag_load0", 32'(tag_load0), 32'd1);
        chk("dm_dirty_select", 32'(dirty_select), 32'd0);
        chk("dm_resp_early", 32'(mem_resp), 32'd0);
        cyc();
        pmem_resp = 1'b0; hit0 = 1'b1;
        #1 chk("dm_mem_resp", 32'(mem_resp), 32'd1);
        chk("dm_w0sel_cpu", 32'(write0_select), 32'd1);
        chk("dm_dirty_load0", 32'(dirty_load0), 32'd1);
        chk("dm_pmem_read_drop", 32'(pmem_read), 32'd0);
        cyc();
        clear_inputs();
        #1 chk("dm_hit_count", 32'(hit_count), 32'd4);
        chk("dm_miss_count_end", 32'(miss_count), 32'd2);

        // Spurious pmem_resp while idle.
        pmem_resp = 1'b1;
        cyc();
        cyc();
        #1 chk("sp_pmem_read", 32'(pmem_read), 32'd0);
        chk("sp_pmem_write", 32'(pmem_write), 32'd0);
        chk("sp_mem_resp", 32'(mem_resp), 32'd0);
        pmem_resp = 1'b0;
        cyc();
        mem_read = 1'b1; hit1 = 1'b1;
        cyc();
        #1 chk("sp_then_hit", 32'(mem_resp), 32'd1);
        cyc();
        clear_inputs();
        #1 chk("sp_miss_count", 32'(miss_count), 32'd2);

        // Read and write together on a way-0 hit is serviced as a write.
        cyc();
        mem_read = 1'b1; mem_write = 1'b1; hit0 = 1'b1;
        cyc();
        #1 chk("rw_w0sel", 32'(write0_select), 32'd1);
        chk("rw_dirty_load0", 32'(dirty_load0), 32'd1);
        cyc();
        clear_inputs();
        #1 chk("rw_hit_count", 32'(hit_count), 32'd6);

        // Counter wrap: 2^CW + 3 hits after a fresh reset.
        #2 rst = 1'b1;
        #1 chk("wr_rst_hit", 32'(hit_count), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < (1 << CW) + 3; i++) begin
            cyc();
            mem_read = 1'b1; hit0 = 1'b1;
            cyc();
            if (i == 0) begin
                #1 chk("wr_first_resp", 32'(mem_resp), 32'd1);
            end
            cyc();
            clear_inputs();
        end
        #1 chk("wr_hit_count", 32'(hit_count), 32'd3);
        chk("wr_miss_count", 32'(miss_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
